// File: rtl/reflet_mem_arbiter.sv
// Round-robin front end serialising two req/ready ports onto one registered-read RAM.
// Write: ready 2 cycles after IDLE sampling; read: ready 3 cycles after. Requesters hold req until ready.
module reflet_mem_arbiter #(
  parameter int addrSize = 7,
  parameter int wordsize = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                a_req,
  input  logic                a_we,
  input  logic [addrSize-1:0] a_addr,
  input  logic [wordsize-1:0] a_wdata,
  output logic [wordsize-1:0] a_rdata,
  output logic                a_ready,
  input  logic                b_req,
  input  logic                b_we,
  input  logic [addrSize-1:0] b_addr,
  input  logic [wordsize-1:0] b_wdata,
  output logic [wordsize-1:0] b_rdata,
  output logic                b_ready,
  output logic                ram_enable,
  output logic [addrSize-1:0] ram_addr,
  output logic                ram_write_en,
  output logic [wordsize-1:0] ram_data_in,
  input  logic [wordsize-1:0] ram_data_out
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  localparam logic PORT_A = 1'b0;
  localparam logic PORT_B = 1'b1;

  state_t              state;
  state_t              state_nxt;
  logic                last_grant;
  logic                grant;
  logic                cur_we;
  logic [addrSize-1:0] cur_addr;
  logic [wordsize-1:0] cur_wdata;

  logic                start;
  logic                pick_b;
  logic                sel_we;
  logic [addrSize-1:0] sel_addr;
  logic [wordsize-1:0] sel_wdata;

  logic                enable_nxt;
  logic                write_en_nxt;
  logic [addrSize-1:0] addr_nxt;
  logic [wordsize-1:0] data_in_nxt;
  logic                a_ready_nxt;
  logic                b_ready_nxt;

  // B wins only if A is absent or A was the last one served.
  always_comb begin
    start     = a_req | b_req;
    pick_b    = b_req & (~a_req | (last_grant == PORT_A));
    sel_we    = pick_b ? b_we    : a_we;
    sel_addr  = pick_b ? b_addr  : a_addr;
    sel_wdata = pick_b ? b_wdata : a_wdata;

    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = ISSUE;
      ISSUE:   state_nxt = cur_we ? DONE : WAIT;
      WAIT:    state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs are decoded from the next state so every output leaves a flop.
  always_comb begin
    enable_nxt   = 1'b0;
    write_en_nxt = 1'b0;
    addr_nxt     = ram_addr;
    data_in_nxt  = ram_data_in;
    a_ready_nxt  = 1'b0;
    b_ready_nxt  = 1'b0;
    case (state_nxt)
      ISSUE: begin
        enable_nxt   = 1'b1;
        write_en_nxt = sel_we;
        addr_nxt     = sel_addr;
        data_in_nxt  = sel_wdata;
      end
      WAIT: begin
        // RAM output is gated by enable, so keep it enabled while data is captured.
        enable_nxt = 1'b1;
        addr_nxt   = cur_addr;
      end
      DONE: begin
        a_ready_nxt = (grant == PORT_A);
        b_ready_nxt = (grant == PORT_B);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ram_enable   <= 1'b0;
      ram_write_en <= 1'b0;
      ram_addr     <= '0;
      ram_data_in  <= '0;
      a_ready      <= 1'b0;
      b_ready      <= 1'b0;
      a_rdata      <= '0;
      b_rdata      <= '0;
      last_grant   <= PORT_B;
      grant        <= PORT_A;
      cur_we       <= 1'b0;
      cur_addr     <= '0;
      cur_wdata    <= '0;
    end else begin
      ram_enable   <= enable_nxt;
      ram_write_en <= write_en_nxt;
      ram_addr     <= addr_nxt;
      ram_data_in  <= data_in_nxt;
      a_ready      <= a_ready_nxt;
      b_ready      <= b_ready_nxt;
      if (state == IDLE && start) begin
        grant      <= pick_b;
        last_grant <= pick_b;
        cur_we     <= sel_we;
        cur_addr   <= sel_addr;
        cur_wdata  <= sel_wdata;
      end
      if (state == WAIT) begin
        if (grant == PORT_A) a_rdata <= ram_data_out;
        else                 b_rdata <= ram_data_out;
      end
    end
  end

endmodule

// File: tb/tb_reflet_mem_arbiter.sv
// Bench for reflet_mem_arbiter: directed scenarios plus a randomized two-port run against a transaction model.
module tb_reflet_mem_arbiter;
  localparam int AW = 7;
  localparam int DW = 8;
  localparam int RAM_SIZE = 100;

  logic          clk = 1'b0;
  logic          reset;
  logic          a_req, a_we, a_ready;
  logic [AW-1:0] a_addr;
  logic [DW-1:0] a_wdata, a_rdata;
  logic          b_req, b_we, b_ready;
  logic [AW-1:0] b_addr;
  logic [DW-1:0] b_wdata, b_rdata;
  logic          ram_enable, ram_write_en;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_data_in, ram_data_out;

  int n_checks = 0;
  int n_fail = 0;
  logic [DW-1:0] exp_a = '0;
  logic [DW-1:0] exp_b = '0;
  logic [DW-1:0] mem [0:RAM_SIZE-1];

  reflet_mem_arbiter #(.addrSize(AW), .wordsize(DW)) dut (
    .clk(clk), .reset(reset),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_rdata(a_rdata), .a_ready(a_ready),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_rdata(b_rdata), .b_ready(b_ready),
    .ram_enable(ram_enable), .ram_addr(ram_addr), .ram_write_en(ram_write_en),
    .ram_data_in(ram_data_in), .ram_data_out(ram_data_out)
  );

  always #5 clk = ~clk;

  // RAM of 100 words with registered read, output 0 when not enabled or out of range.
  always @(posedge clk) begin
    if (ram_enable) begin
      if (ram_write_en) begin
        if (int'(ram_addr) < RAM_SIZE) mem[ram_addr] <= ram_data_in;
        ram_data_out <= '0;
      end else begin
        ram_data_out <= (int'(ram_addr) < RAM_SIZE) ? mem[ram_addr] : '0;
      end
    end else begin
      ram_data_out <= '0;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; a_req = 1'b0; b_req = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    exp_a = '0; exp_b = '0;
  endtask

  // Raises one request in an IDLE cycle and watches five cycles; req drops on its ready.
  task automatic access(input bit port, input bit we, input logic [AW-1:0] addr,
                        input logic [DW-1:0] wd, input int chg_at, input logic [AW-1:0] chg_addr,
                        output int lat, output int pulses, output int other,
                        output logic [DW-1:0] rd);
    lat = -1; pulses = 0; other = 0; rd = '0;
    if (port == 1'b0) begin a_req = 1'b1; a_we = we; a_addr = addr; a_wdata = wd; end
    else              begin b_req = 1'b1; b_we = we; b_addr = addr; b_wdata = wd; end
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      if (k == chg_at) begin
        if (port == 1'b0) begin a_addr = chg_addr; a_we = ~we; a_wdata = ~wd; end
        else              begin b_addr = chg_addr; b_we = ~we; b_wdata = ~wd; end
      end
      if (((port == 1'b0) ? a_ready : b_ready) === 1'b1) begin
        pulses++;
        if (lat < 0) begin
          lat = k;
          rd = (port == 1'b0) ? a_rdata : b_rdata;
        end
        if (port == 1'b0) a_req = 1'b0; else b_req = 1'b0;
      end
      if (((port == 1'b0) ? b_ready : a_ready) === 1'b1) other++;
    end
  endtask

  task automatic test_reset();
    logic [2*AW+4*DW+3:0] outs;
    @(negedge clk);
    reset = 1'b1;
    a_req = 1'b1; a_we = 1'b1; a_addr = 7'h11; a_wdata = 8'h3C;
    b_req = 1'b1; b_we = 1'b0; b_addr = 7'h7F; b_wdata = 8'h00;
    repeat (2) begin
      @(negedge clk);
      outs = {ram_enable, ram_write_en, ram_addr, ram_data_in, a_ready, b_ready, a_rdata, b_rdata, ram_addr};
      n_checks++;
      if (outs !== '0) $display("FAIL reset_outputs: got %h required 0", outs);
      if (outs !== '0) n_fail++;
    end
    reset = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({ram_enable, ram_write_en, ram_addr, ram_data_in} !== {1'b1, 1'b1, 7'h11, 8'h3C}) begin
      $display("FAIL reset_first_grant_A: en=%b we=%b addr=%h din=%h required 1 1 11 3c",
               ram_enable, ram_write_en, ram_addr, ram_data_in);
      n_fail++;
    end
    @(negedge clk);
    n_checks++;
    if ({a_ready, b_ready} !== 2'b10) begin
      $display("FAIL reset_a_ready: got %b required 10", {a_ready, b_ready});
      n_fail++;
    end
    a_req = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++;
    if ({ram_enable, ram_write_en, ram_addr} !== {1'b1, 1'b0, 7'h7F}) begin
      $display("FAIL reset_then_b_issue: en=%b we=%b addr=%h required 1 0 7f",
               ram_enable, ram_write_en, ram_addr);
      n_fail++;
    end
    repeat (2) @(negedge clk);
    n_checks++;
    if ({a_ready, b_ready, b_rdata} !== {2'b01, 8'h00}) begin
      $display("FAIL reset_then_b_done: ready=%b b_rdata=%h required 01 00", {a_ready, b_ready}, b_rdata);
      n_fail++;
    end
    b_req = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_write_read();
    int lat, p, o;
    logic [DW-1:0] rd;
    access(1'b0, 1'b1, 7'h11, 8'h00, 0, 7'h00, lat, p, o, rd);
    access(1'b0, 1'b0, 7'h11, 8'h00, 0, 7'h00, lat, p, o, rd);
    n_checks++;
    if (rd !== 8'h00 || lat != 3) begin
      $display("FAIL write_read_reset_commit: rd=%h lat=%0d required 00 3", rd, lat);
      n_fail++;
    end
    access(1'b0, 1'b1, 7'h05, 8'hA5, 0, 7'h00, lat, p, o, rd);
    n_checks++;
    if (lat != 2 || p != 1 || o != 0) begin
      $display("FAIL write_latency: lat=%0d pulses=%0d other=%0d required 2 1 0", lat, p, o);
      n_fail++;
    end
    access(1'b0, 1'b0, 7'h05, 8'h00, 0, 7'h00, lat, p, o, rd);
    exp_a = 8'hA5;
    n_checks++;
    if (lat != 3 || p != 1 || o != 0 || rd !== 8'hA5 || b_rdata !== exp_b) begin
      $display("FAIL read_latency_data: lat=%0d pulses=%0d other=%0d rd=%h b_rdata=%h required 3 1 0 a5 %h",
               lat, p, o, rd, b_rdata, exp_b);
      n_fail++;
    end
  endtask

  task automatic test_addr_change();
    int lat, p, o;
    logic [DW-1:0] rd;
    access(1'b0, 1'b1, 7'h10, 8'h5A, 0, 7'h00, lat, p, o, rd);
    access(1'b1, 1'b1, 7'h20, 8'hC3, 0, 7'h00, lat, p, o, rd);
    for (int c = 1; c <= 2; c++) begin
      access(1'b0, 1'b0, 7'h10, 8'h00, c, 7'h20, lat, p, o, rd);
      n_checks++;
      if (rd !== 8'h5A || p != 1 || lat != 3) begin
        $display("FAIL addr_change_at_%0d: rd=%h pulses=%0d lat=%0d required 5a 1 3", c, rd, p, lat);
        n_fail++;
      end
    end
    access(1'b1, 1'b0, 7'h20, 8'h00, 0, 7'h00, lat, p, o, rd);
    exp_a = 8'h5A; exp_b = 8'hC3;
    n_checks++;
    if (rd !== 8'hC3 || a_rdata !== exp_a) begin
      $display("FAIL addr_change_no_stray_write: rd=%h a_rdata=%h required c3 5a", rd, a_rdata);
      n_fail++;
    end
  endtask

  task automatic test_oob();
    int lat, p, o;
    logic [DW-1:0] rd;
    access(1'b1, 1'b1, 7'h30, 8'h99, 0, 7'h00, lat, p, o, rd);
    access(1'b1, 1'b0, 7'h30, 8'h00, 0, 7'h00, lat, p, o, rd);
    exp_b = 8'h99;
    n_checks++;
    if (rd !== 8'h99) begin
      $display("FAIL b_read_back: got %h required 99", rd);
      n_fail++;
    end
    access(1'b1, 1'b0, 7'h7F, 8'h00, 0, 7'h00, lat, p, o, rd);
    exp_b = 8'h00;
    n_checks++;
    if (rd !== 8'h00 || lat != 3 || p != 1 || o != 0 || a_rdata !== exp_a) begin
      $display("FAIL oob_read: rd=%h lat=%0d pulses=%0d other=%0d a_rdata=%h required 00 3 1 0 %h",
               rd, lat, p, o, a_rdata, exp_a);
      n_fail++;
    end
  endtask

  task automatic test_alternate();
    int lat, p, o, prev, np, first_k, first_p;
    logic [DW-1:0] rd;
    access(1'b0, 1'b1, 7'h40, 8'h41, 0, 7'h00, lat, p, o, rd);
    access(1'b1, 1'b1, 7'h41, 8'hB2, 0, 7'h00, lat, p, o, rd);
    prev = -1; np = 0; first_k = -1; first_p = -1;
    a_req = 1'b1; a_we = 1'b0; a_addr = 7'h40;
    b_req = 1'b1; b_we = 1'b0; b_addr = 7'h41;
    for (int k = 1; k <= 32; k++) begin
      @(negedge clk);
      if (k == 32) begin a_req = 1'b0; b_req = 1'b0; end
      if (a_ready === 1'b1 || b_ready === 1'b1) begin
        np++;
        if (first_k < 0) begin first_k = k; first_p = (a_ready === 1'b1) ? 0 : 1; end
      end
      if (a_ready === 1'b1) begin
        exp_a = 8'h41;
        n_checks++;
        if (prev == 0 || b_ready !== 1'b0 || a_rdata !== exp_a || b_rdata !== exp_b) begin
          $display("FAIL alternate_a: cycle %0d prev=%0d a_rdata=%h b_rdata=%h required 41 %h",
                   k, prev, a_rdata, b_rdata, exp_b);
          n_fail++;
        end
        prev = 0;
      end else if (b_ready === 1'b1) begin
        exp_b = 8'hB2;
        n_checks++;
        if (prev == 1 || b_rdata !== exp_b || a_rdata !== exp_a) begin
          $display("FAIL alternate_b: cycle %0d prev=%0d b_rdata=%h a_rdata=%h required b2 %h",
                   k, prev, b_rdata, a_rdata, exp_a);
          n_fail++;
        end
        prev = 1;
      end
    end
    n_checks++;
    if (np != 8 || first_k != 3 || first_p != 0) begin
      $display("FAIL alternate_count: pulses=%0d first_cycle=%0d first_port=%0d required 8 3 0",
               np, first_k, first_p);
      n_fail++;
    end
  endtask

  task automatic test_back_to_back();
    int np, prev_k;
    for (int mode = 0; mode < 2; mode++) begin
      np = 0; prev_k = (mode == 0) ? -1 : -1;
      a_req = 1'b1; a_we = (mode == 0); a_addr = 7'h50; a_wdata = 8'h77;
      for (int k = 1; k <= 32; k++) begin
        @(negedge clk);
        if (a_ready === 1'b1) begin
          n_checks++;
          if ((prev_k < 0 && k != 3 - (mode == 0 ? 1 : 0)) ||
              (prev_k >= 0 && k - prev_k != (mode == 0 ? 3 : 4)) ||
              (mode == 1 && a_rdata !== 8'h77)) begin
            $display("FAIL back_to_back_mode%0d: pulse at %0d prev %0d a_rdata=%h", mode, k, prev_k, a_rdata);
            n_fail++;
          end
          np++; prev_k = k;
        end
        if ((mode == 0 && k == 30) || k == 32) a_req = 1'b0;
        if (mode == 0 && k == 30) break;
      end
      n_checks++;
      if (np != (mode == 0 ? 10 : 8)) begin
        $display("FAIL back_to_back_count%0d: got %0d required %0d", mode, np, (mode == 0 ? 10 : 8));
        n_fail++;
      end
    end
    exp_a = 8'h77;
  endtask

  task automatic test_reset_mid();
    int lat, p, o, np;
    logic [DW-1:0] rd;
    b_req = 1'b1; b_we = 1'b0; b_addr = 7'h30;
    repeat (2) @(negedge clk);
    reset = 1'b1; b_req = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({b_ready, b_rdata, ram_enable, ram_write_en} !== 11'd0) begin
      $display("FAIL reset_mid_read: b_ready=%b b_rdata=%h en=%b we=%b required 0 00 0 0",
               b_ready, b_rdata, ram_enable, ram_write_en);
      n_fail++;
    end
    reset = 1'b0; exp_a = '0; exp_b = '0;
    np = 0;
    repeat (3) begin
      @(negedge clk);
      if (a_ready === 1'b1 || b_ready === 1'b1) np++;
    end
    n_checks++;
    if (np != 0) begin
      $display("FAIL reset_mid_no_ready: got %0d pulses required 0", np);
      n_fail++;
    end
    a_req = 1'b1; a_we = 1'b1; a_addr = 7'h60; a_wdata = 8'hE1;
    @(negedge clk);
    reset = 1'b1; a_req = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({ram_write_en, a_ready} !== 2'b00) begin
      $display("FAIL reset_mid_write: we=%b a_ready=%b required 0 0", ram_write_en, a_ready);
      n_fail++;
    end
    reset = 1'b0;
    access(1'b0, 1'b0, 7'h60, 8'h00, 0, 7'h00, lat, p, o, rd);
    exp_a = 8'hE1;
    n_checks++;
    if (rd !== 8'hE1 || lat != 3) begin
      $display("FAIL reset_mid_write_committed: rd=%h lat=%0d required e1 3", rd, lat);
      n_fail++;
    end
    access(1'b1, 1'b0, 7'h30, 8'h00, 0, 7'h00, lat, p, o, rd);
    exp_b = 8'h99;
    n_checks++;
    if (rd !== 8'h99 || lat != 3 || p != 1) begin
      $display("FAIL reset_mid_recover: rd=%h lat=%0d pulses=%0d required 99 3 1", rd, lat, p);
      n_fail++;
    end
  endtask

  task automatic test_random();
    logic [DW-1:0] refm [0:127];
    bit pend [2];
    bit we_q [2];
    logic [AW-1:0] ad_q [2];
    logic [DW-1:0] wd_q [2];
    int gnt, ready_at, free_at, last, lat, p, o, w;
    logic [DW-1:0] rd, exp_rd, wv;
    bit er;
    do_reset();
    last = 1;
    for (int i = 0; i < 128; i++) refm[i] = '0;
    for (int i = 0; i < RAM_SIZE; i++) begin
      w = int'($urandom_range(1, 0));
      wv = 8'($urandom);
      access(w[0], 1'b1, 7'(i), wv, 0, 7'h00, lat, p, o, rd);
      refm[i] = wv; last = w;
      n_checks++;
      if (lat != 2 || o != 0) begin
        $display("FAIL fill_write: addr %0d lat=%0d other=%0d required 2 0", i, lat, o);
        n_fail++;
      end
    end
    pend[0] = 0; pend[1] = 0; gnt = -1; ready_at = -1; free_at = 0; exp_rd = '0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      for (int q = 0; q < 2; q++) begin
        er = (gnt == q && ready_at == cyc);
        n_checks++;
        if (((q == 0) ? a_ready : b_ready) !== er) begin
          $display("FAIL random_ready port %0d cycle %0d: got %b required %b", q, cyc,
                   (q == 0) ? a_ready : b_ready, er);
          n_fail++;
        end
      end
      if (gnt >= 0 && ready_at == cyc) begin
        if (!we_q[gnt]) begin
          if (gnt == 0) exp_a = exp_rd; else exp_b = exp_rd;
        end
        pend[gnt] = 0; gnt = -1; free_at = cyc + 1;
      end
      n_checks++;
      if (a_rdata !== exp_a || b_rdata !== exp_b) begin
        $display("FAIL random_rdata cycle %0d: a=%h b=%h required %h %h", cyc, a_rdata, b_rdata, exp_a, exp_b);
        n_fail++;
      end
      for (int q = 0; q < 2; q++) begin
        if (!pend[q] && $urandom_range(1, 0) == 1) begin
          pend[q] = 1; we_q[q] = 1'($urandom_range(1, 0));
          ad_q[q] = 7'($urandom_range(127, 0)); wd_q[q] = 8'($urandom);
        end
      end
      a_req = pend[0]; a_we = we_q[0]; a_addr = ad_q[0]; a_wdata = wd_q[0];
      b_req = pend[1]; b_we = we_q[1]; b_addr = ad_q[1]; b_wdata = wd_q[1];
      if (gnt < 0 && cyc == free_at) begin
        if (pend[0] || pend[1]) begin
          gnt = (pend[0] && (!pend[1] || last == 1)) ? 0 : 1;
          last = gnt;
          ready_at = cyc + (we_q[gnt] ? 2 : 3);
          if (we_q[gnt]) begin
            if (int'(ad_q[gnt]) < RAM_SIZE) refm[ad_q[gnt]] = wd_q[gnt];
          end else begin
            exp_rd = (int'(ad_q[gnt]) < RAM_SIZE) ? refm[ad_q[gnt]] : 8'h00;
          end
        end else begin
          free_at = cyc + 1;
        end
      end
      @(negedge clk);
    end
    a_req = 1'b0; b_req = 1'b0;
    repeat (5) @(negedge clk);
  endtask

  initial begin
    reset = 1'b1;
    a_req = 1'b0; a_we = 1'b0; a_addr = '0; a_wdata = '0;
    b_req = 1'b0; b_we = 1'b0; b_addr = '0; b_wdata = '0;
    test_reset();
    test_write_read();
    test_addr_change();
    test_oob();
    test_alternate();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
